// File: rtl/tile_frame_buffer.sv
// Tile frame buffer: beat-wide RAM with a fragment port, AXIS commit and clipped memset.
// Scissor logic is present only when FRAMEBUFFER_SCISSOR_EN is defined.
module tile_frame_buffer #(
    parameter int STREAM_WIDTH         = 64,
    parameter int NUMBER_OF_SUB_PIXELS = 4,
    parameter int SUB_PIXEL_WIDTH      = 8,
    parameter int X_RESOLUTION         = 1024,
    parameter int Y_LINE_RESOLUTION    = 32,
    parameter int SCREEN_POS_WIDTH     = 16,
    localparam int PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int IW = $clog2(X_RESOLUTION * Y_LINE_RESOLUTION)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        confScissorEnable,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorStartX,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorStartY,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorEndX,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorEndY,
    input  logic [11:0]                 confYOffset,
    input  logic [IW-1:0]               fragIndexRead,
    output logic [PIXEL_WIDTH-1:0]      fragOut,
    input  logic [IW-1:0]               fragIndexWrite,
    input  logic [PIXEL_WIDTH-1:0]      fragIn,
    input  logic                        fragWriteEnable,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] fragMask,
    input  logic [SCREEN_POS_WIDTH-1:0] screenPosX,
    input  logic [SCREEN_POS_WIDTH-1:0] screenPosY,
    input  logic                        apply,
    output logic                        applied,
    input  logic                        cmdCommit,
    input  logic                        cmdMemset,
    input  logic [PIXEL_WIDTH-1:0]      clearColor,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]     m_axis_tdata
);
    localparam int PPB   = STREAM_WIDTH / PIXEL_WIDTH;
    localparam int LW    = $clog2(PPB);
    localparam int BEATS = X_RESOLUTION * Y_LINE_RESOLUTION / PPB;
    localparam int AW    = IW - LW;
    localparam int BPL   = X_RESOLUTION / PPB;
    localparam int STRB  = PPB * NUMBER_OF_SUB_PIXELS;
    localparam int CW    = SCREEN_POS_WIDTH + 2;
    localparam int NW    = $clog2(Y_LINE_RESOLUTION + 1);
    localparam int NSP   = NUMBER_OF_SUB_PIXELS;
    localparam int SPW   = SUB_PIXEL_WIDTH;

    typedef enum logic [2:0] {
        IDLE, COMMIT_PREFETCH, COMMIT, MEMSET_INIT, MEMSET
    } state_t;

    state_t state, state_nx;

    logic [STREAM_WIDTH-1:0] mem [BEATS];
    logic [STREAM_WIDTH-1:0] ram_q, wdata;
    logic [AW-1:0]           raddr, waddr;
    logic [STRB-1:0]         wstrb, ms_strb;

    logic                   ms_en;
    logic [PIXEL_WIDTH-1:0] clear_q;
    logic [NSP-1:0]         mask_q;
    logic [LW-1:0]          lane_q;

    logic                    commit_st, pop, issue;
    logic [1:0]              occ;
    logic [AW:0]             rd_cnt;
    logic                    pend, pend_last;
    logic                    out_valid, out_last, skid_valid, skid_last;
    logic [STREAM_WIDTH-1:0] out_data, skid_data;

    logic [AW-1:0] row_q, bx_q, bx0_q, bx1_q, bx0, bx1, row0;
    logic [NW-1:0] lines_q, nlines;
    logic [CW-1:0] xlo_q, xhi_q;
    logic [CW-1:0] y_base, y_top, x_lo, x_hi, y_lo, y_hi, lmin;
    logic          rect_empty, sc_en, frag_in_sc;

`ifdef FRAMEBUFFER_SCISSOR_EN
    assign sc_en = confScissorEnable;
    assign frag_in_sc = !confScissorEnable ||
        (screenPosX >= confScissorStartX && screenPosX < confScissorEndX &&
         screenPosY >= confScissorStartY && screenPosY < confScissorEndY);
`else
    logic unused_scissor;
    assign sc_en = 1'b0;
    assign frag_in_sc = 1'b1;
    assign unused_scissor = ^{confScissorEnable, screenPosX, screenPosY};
`endif

    // Clip rectangle in screen space; tile line 0 is the topmost screen line.
    assign y_base = CW'(confYOffset);
    assign y_top  = y_base + CW'(Y_LINE_RESOLUTION);
    assign x_lo   = sc_en ? CW'(confScissorStartX) : '0;
    assign x_hi   = (sc_en && CW'(confScissorEndX) < CW'(X_RESOLUTION))
                  ? CW'(confScissorEndX) : CW'(X_RESOLUTION);
    assign y_lo   = (sc_en && CW'(confScissorStartY) > y_base)
                  ? CW'(confScissorStartY) : y_base;
    assign y_hi   = (sc_en && CW'(confScissorEndY) < y_top)
                  ? CW'(confScissorEndY) : y_top;
    assign rect_empty = (x_lo >= x_hi) || (y_lo >= y_hi);
    assign lmin   = y_top - y_hi;
    assign nlines = NW'(y_hi - y_lo);
    assign bx0    = AW'(x_lo >> LW);
    assign bx1    = AW'((x_hi - 1'b1) >> LW);
    assign row0   = AW'(lmin * CW'(BPL));

    always_comb begin
        ms_strb = '0;
        for (int p = 0; p < PPB; p++) begin
            if (CW'({bx_q, LW'(p)}) >= xlo_q && CW'({bx_q, LW'(p)}) < xhi_q)
                ms_strb[p*NSP +: NSP] = mask_q;
        end
    end

    always_comb begin
        waddr = fragIndexWrite[IW-1:LW];
        wdata = {PPB{fragIn}};
        wstrb = '0;
        if (state == MEMSET) begin
            waddr = row_q + bx_q;
            wdata = {PPB{clear_q}};
            wstrb = ms_strb;
        end else if (state == IDLE && fragWriteEnable && frag_in_sc) begin
            wstrb = STRB'(fragMask) << (NSP * fragIndexWrite[LW-1:0]);
        end
        if (reset)
            wstrb = '0;
    end

    assign raddr = (state == IDLE) ? fragIndexRead[IW-1:LW] : rd_cnt[AW-1:0];

    always_ff @(posedge clk) begin
        for (int s = 0; s < STRB; s++) begin
            if (wstrb[s])
                mem[waddr][s*SPW +: SPW] <= wdata[s*SPW +: SPW];
        end
        ram_q <= mem[raddr];
    end

    // Commit: out register plus one skid entry; reads issued only when a slot is free.
    assign commit_st = (state == COMMIT_PREFETCH) || (state == COMMIT);
    assign pop   = out_valid && m_axis_tready;
    assign occ   = 2'(out_valid) + 2'(skid_valid) + 2'(pend) - 2'(pop);
    assign issue = commit_st && (rd_cnt < (AW+1)'(BEATS)) && (occ < 2'd2);

    always_ff @(posedge clk) begin
        if (reset || !commit_st) begin
            rd_cnt     <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
        end else begin
            pend      <= issue;
            pend_last <= issue && (rd_cnt == (AW+1)'(BEATS - 1));
            if (issue)
                rd_cnt <= rd_cnt + 1'b1;
            if (!out_valid || m_axis_tready) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    skid_valid <= pend;
                    skid_data  <= ram_q;
                    skid_last  <= pend_last;
                end else begin
                    out_valid <= pend;
                    out_data  <= ram_q;
                    out_last  <= pend_last;
                end
            end else if (pend) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_q;
                skid_last  <= pend_last;
            end
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_valid && out_last;
    assign m_axis_tdata  = out_data;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (apply) begin
                    if (cmdCommit)
                        state_nx = COMMIT_PREFETCH;
                    else if (cmdMemset)
                        state_nx = MEMSET_INIT;
                end
            COMMIT_PREFETCH:
                state_nx = COMMIT;
            COMMIT:
                if (pop && out_last)
                    state_nx = ms_en ? MEMSET_INIT : IDLE;
            MEMSET_INIT:
                state_nx = rect_empty ? IDLE : MEMSET;
            MEMSET:
                if (bx_q == bx1_q && lines_q == NW'(1))
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            applied <= 1'b1;
        end else begin
            state   <= state_nx;
            applied <= (state_nx == IDLE) && !(state == IDLE && apply);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && apply) begin
            ms_en   <= cmdMemset;
            clear_q <= clearColor;
            mask_q  <= fragMask;
        end
        if (state == MEMSET_INIT) begin
            row_q   <= row0;
            bx_q    <= bx0;
            bx0_q   <= bx0;
            bx1_q   <= bx1;
            lines_q <= nlines;
            xlo_q   <= x_lo;
            xhi_q   <= x_hi;
        end else if (state == MEMSET) begin
            if (bx_q == bx1_q) begin
                bx_q    <= bx0_q;
                row_q   <= row_q + AW'(BPL);
                lines_q <= lines_q - 1'b1;
            end else begin
                bx_q <= bx_q + 1'b1;
            end
        end
        lane_q  <= fragIndexRead[LW-1:0];
        fragOut <= ram_q[lane_q*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
endmodule

// File: tb/tb_tile_frame_buffer.sv
// Directed bench for tile_frame_buffer: 16x4 tile, 16-bit pixels, 64-bit stream.
module tb_tile_frame_buffer;
    localparam int IW = 6;

`ifdef FRAMEBUFFER_SCISSOR_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        confScissorEnable = 1'b0;
    logic [15:0] confScissorStartX = '0, confScissorStartY = '0;
    logic [15:0] confScissorEndX = '0, confScissorEndY = '0;
    logic [11:0] confYOffset = '0;
    logic [IW-1:0] fragIndexRead = '0, fragIndexWrite = '0;
    logic [15:0] fragOut, fragIn = '0;
    logic        fragWriteEnable = 1'b0;
    logic [3:0]  fragMask = '0;
    logic [15:0] screenPosX = '0, screenPosY = '0;
    logic        apply = 1'b0, applied, cmdCommit = 1'b0, cmdMemset = 1'b0;
    logic [15:0] clearColor = '0;
    logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
    logic [63:0] m_axis_tdata;

    always #5 clk = ~clk;

    tile_frame_buffer #(
        .STREAM_WIDTH(64), .NUMBER_OF_SUB_PIXELS(4), .SUB_PIXEL_WIDTH(4),
        .X_RESOLUTION(16), .Y_LINE_RESOLUTION(4), .SCREEN_POS_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .confScissorEnable(confScissorEnable),
        .confScissorStartX(confScissorStartX), .confScissorStartY(confScissorStartY),
        .confScissorEndX(confScissorEndX), .confScissorEndY(confScissorEndY),
        .confYOffset(confYOffset),
        .fragIndexRead(fragIndexRead), .fragOut(fragOut),
        .fragIndexWrite(fragIndexWrite), .fragIn(fragIn),
        .fragWriteEnable(fragWriteEnable), .fragMask(fragMask),
        .screenPosX(screenPosX), .screenPosY(screenPosY),
        .apply(apply), .applied(applied),
        .cmdCommit(cmdCommit), .cmdMemset(cmdMemset), .clearColor(clearColor),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] shadow [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int b);
        return {shadow[4*b+3], shadow[4*b+2], shadow[4*b+1], shadow[4*b]};
    endfunction

    task automatic wr_px(input int idx, input logic [15:0] val, input logic [3:0] mask,
                         input logic [15:0] sx, input logic [15:0] sy);
        fragIndexWrite = IW'(idx);
        fragIn = val;
        fragMask = mask;
        screenPosX = sx;
        screenPosY = sy;
        fragWriteEnable = 1'b1;
        @(negedge clk);
        fragWriteEnable = 1'b0;
    endtask

    task automatic rd_px(input int idx, output logic [15:0] val);
        fragIndexRead = IW'(idx);
        @(negedge clk);
        @(negedge clk);
        val = fragOut;
    endtask

    task automatic verify_all(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 64; i++) begin
            rd_px(i, v);
            check($sformatf("%s_px%0d", tag, i), 64'(v), 64'(shadow[i]));
        end
    endtask

    task automatic start_apply(input logic commit, input logic memset,
                               input logic [15:0] color, input logic [3:0] mask);
        apply = 1'b1;
        cmdCommit = commit;
        cmdMemset = memset;
        clearColor = color;
        fragMask = mask;
        @(negedge clk);
        apply = 1'b0;
        cmdCommit = 1'b0;
        cmdMemset = 1'b0;
    endtask

    task automatic wait_applied(output int cyc);
        cyc = 1;
        while (!applied && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [63:0] held;
        int cyc, beat, first;
        bit stalled;

        repeat (3) @(negedge clk);
        check("rst_applied", 64'(applied), 64'd1);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_applied", 64'(applied), 64'd1);

        // Full memset with scissor off gives a known background.
        start_apply(1'b0, 1'b1, 16'h0F0F, 4'hF);
        wait_applied(cyc);
        check("ms_full_cyc", 64'(cyc <= 18), 64'd1);
        for (int i = 0; i < 64; i++) shadow[i] = 16'h0F0F;

        wr_px(5, 16'hABCD, 4'hF, 16'd0, 16'd0);
        shadow[5] = 16'hABCD;
        rd_px(5, v);
        check("wr5", 64'(v), 64'hABCD);
        rd_px(4, v);
        check("wr5_left", 64'(v), 64'h0F0F);
        rd_px(6, v);
        check("wr5_right", 64'(v), 64'h0F0F);

        wr_px(9, 16'h1234, 4'b0101, 16'd0, 16'd0);
        shadow[9] = 16'h0204;
        rd_px(9, v);
        check("wr9_mask", 64'(v), 64'h0204);

        for (int i = 16; i < 32; i++) begin
            wr_px(i, 16'h3000 | 16'(i * 16'h0111), 4'hF, 16'd0, 16'd0);
            shadow[i] = 16'h3000 | 16'(i * 16'h0111);
        end

        // Same-address read and write in one cycle return the old word.
        fragIndexRead = 6'd12;
        wr_px(12, 16'h7777, 4'hF, 16'd0, 16'd0);
        @(negedge clk);
        check("rw_old", 64'(fragOut), 64'h0F0F);
        shadow[12] = 16'h7777;
        rd_px(12, v);
        check("rw_new", 64'(v), 64'h7777);

        // Commit, tready held high.
        m_axis_tready = 1'b1;
        start_apply(1'b1, 1'b0, 16'h0, 4'h0);
        beat = 0;
        first = -1;
        cyc = 0;
        while (beat < 16 && cyc < 100) begin
            if (m_axis_tvalid) begin
                if (first < 0) first = cyc;
                check($sformatf("c1_data%0d", beat), m_axis_tdata, exp_beat(beat));
                check($sformatf("c1_last%0d", beat), 64'(m_axis_tlast), 64'(beat == 15));
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        check("c1_beats", 64'(beat), 64'd16);
        check("c1_span", 64'(cyc - first), 64'd16);
        check("c1_applied", 64'(applied), 64'd1);
        check("c1_tvalid_off", 64'(m_axis_tvalid), 64'd0);

        // Commit, tready toggling.
        m_axis_tready = 1'b0;
        start_apply(1'b1, 1'b0, 16'h0, 4'h0);
        beat = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (beat < 16 && cyc < 200) begin
            m_axis_tready = ~m_axis_tready;
            if (m_axis_tvalid) begin
                if (stalled)
                    check($sformatf("c2_hold%0d", beat), m_axis_tdata, held);
                if (m_axis_tready) begin
                    check($sformatf("c2_data%0d", beat), m_axis_tdata, exp_beat(beat));
                    check($sformatf("c2_last%0d", beat), 64'(m_axis_tlast), 64'(beat == 15));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = m_axis_tdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("c2_beats", 64'(beat), 64'd16);
        repeat (2) @(negedge clk);
        check("c2_no_extra", 64'(m_axis_tvalid), 64'd0);
        check("c2_applied", 64'(applied), 64'd1);

        // Scissored memset: X [2,6), screen Y [101,103) -> tile lines 2 and 1.
        confYOffset = 12'd100;
        confScissorEnable = 1'b1;
        confScissorStartX = 16'd2;
        confScissorEndX = 16'd6;
        confScissorStartY = 16'd101;
        confScissorEndY = 16'd103;
        start_apply(1'b0, 1'b1, 16'h1234, 4'hF);
        wait_applied(cyc);
        check("ms_sc_cyc", 64'(cyc <= (SC ? 6 : 18)), 64'd1);
        for (int l = 0; l < 4; l++)
            for (int x = 0; x < 16; x++)
                if (!SC || ((l == 1 || l == 2) && x >= 2 && x < 6))
                    shadow[l*16 + x] = 16'h1234;
        verify_all("ms_sc");

        // Fragment writes under the same scissor.
        wr_px(40, 16'hDEAD, 4'hF, 16'd8, 16'd101);
        if (!SC) shadow[40] = 16'hDEAD;
        wr_px(41, 16'hBEEF, 4'hF, 16'd3, 16'd101);
        shadow[41] = 16'hBEEF;
        rd_px(40, v);
        check("fw_outside", 64'(v), 64'(shadow[40]));
        rd_px(41, v);
        check("fw_inside", 64'(v), 64'hBEEF);

        // Empty scissor rectangle.
        confScissorStartX = 16'd0;
        confScissorEndX = 16'd0;
        confScissorStartY = 16'd0;
        confScissorEndY = 16'd0;
        start_apply(1'b0, 1'b1, 16'hFFFF, 4'hF);
        wait_applied(cyc);
        check("ms_empty_cyc", 64'(cyc <= (SC ? 3 : 18)), 64'd1);
        if (!SC)
            for (int i = 0; i < 64; i++) shadow[i] = 16'hFFFF;
        verify_all("ms_empty");

        // Partial sub-pixel mask memset, scissor off.
        confScissorEnable = 1'b0;
        start_apply(1'b0, 1'b1, 16'h00AB, 4'b0011);
        wait_applied(cyc);
        check("ms_mask_done", 64'(applied), 64'd1);
        for (int i = 0; i < 64; i++) shadow[i] = (shadow[i] & 16'hFF00) | 16'h00AB;
        rd_px(0, v);
        check("ms_mask_px0", 64'(v), 64'(shadow[0]));
        rd_px(41, v);
        check("ms_mask_px41", 64'(v), 64'(shadow[41]));

        // Reset at beat 7 of commit+memset aborts both.
        m_axis_tready = 1'b1;
        start_apply(1'b1, 1'b1, 16'h5A5A, 4'hF);
        beat = 0;
        cyc = 0;
        while (cyc < 100) begin
            if (m_axis_tvalid) begin
                if (beat == 7) break;
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        check("ab_reached7", 64'(beat), 64'd7);
        reset = 1'b1;
        @(negedge clk);
        check("ab_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("ab_tlast", 64'(m_axis_tlast), 64'd0);
        check("ab_applied", 64'(applied), 64'd1);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("ab_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("ab_idle_applied", 64'(applied), 64'd1);
        verify_all("ab");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
